mdu: RTL and testbench
======================

// Module: mdu
// PURPOSE
//   Multi-cycle multiply/divide unit sitting beside the ALU in the EX stage.
//   - Takes the same rs/rt operands (a, b) that feed the ALU.
//   - Executes MULT/MULTU/DIV/DIVU iteratively and holds results in HI/LO.
//   - Raises busy so the hazard unit stalls MFHI/MFLO and any new mult/div.
//   - Also services MTHI/MTLO; HI/LO are read by the EX mux for MFHI/MFLO.
// PARAMETERS
//   WIDTH  32  operand width; HI/LO are WIDTH bits; iteration count = WIDTH
// PORTS
//   clk    in   1      single clock, rising edge
//   rst    in   1      synchronous reset, active-high
//   start  in   1      one-cycle request; op/a/b sampled on this edge
//   op     in   3      `MDUOp_MULT/MULTU/DIV/DIVU/MTHI/MTLO (ctrl_encode_def.v)
//   a      in   WIDTH  rs operand (dividend / multiplicand / MTHI,MTLO source)
//   b      in   WIDTH  rt operand (divisor / multiplier)
//   busy   out  1      operation in progress; HI/LO not yet valid
//   hi     out  WIDTH  HI register (product[63:32] / remainder)
//   lo     out  WIDTH  LO register (product[31:0]  / quotient)
// BEHAVIOUR
//   Reset: rst=1 at an edge forces state=IDLE, busy=0, hi=0, lo=0; aborts any op.
//   - rst beats start in the same cycle.
//   FSM: IDLE -> MUL | DIV -> FIX -> IDLE.
//   - IDLE, start & MULT/MULTU/DIV/DIVU: latch |a|,|b| (abs only for signed ops),
//     record result signs, clear iteration counter; go MUL or DIV.
//   - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles.
//   - DIV: restoring shift-subtract, one quotient bit per cycle, WIDTH cycles.
//   - FIX: apply signs, write hi/lo, return to IDLE.
//     - Product negated if sign(a)!=sign(b).
//     - Quotient negated if signs differ; remainder takes sign of a.
//   Latency:
//   - busy=1 for exactly WIDTH+1 cycles after the start edge.
//   - hi/lo change only at the edge where busy falls.
//   - A new start is accepted in the first cycle busy=0.
//   MTHI/MTLO in IDLE: hi (resp. lo) <= a at that edge; busy stays 0; other reg kept.
//   start while busy: ignored entirely (hazard unit must not issue it).
//   - The op in flight is unaffected.
//   Undefined op with start: ignored, stay IDLE.
//   Arithmetic edge cases:
//   - Divide by zero (b==0): lo=all ones, hi=a; same latency; no exception.
//   - Signed overflow DIV 0x80000000 / -1: lo=0x80000000, hi=0 (wrap, no trap).
//   - abs(0x80000000) handled as unsigned 2^31; no overflow in iteration.
//   - Multiply result is the full 2*WIDTH bits; never truncated.
//   hi/lo hold their value indefinitely between operations.
// STRUCTURE
//   ctrl_encode_def.v (shared): add `MDUOp_MULT=3'd0, MULTU=1, DIV=2, DIVU=3,
//   MTHI=4, MTLO=5; state encodings stay local to mdu.
//   Sub-module mdu_iter_core: one shift-add / shift-subtract step.
//   - Combinational, WIDTH-wide; instantiated once.
//   - Selected by mul/div.
// TESTING
//   1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF
//     -> busy high 33 cycles; hi=0xFFFFFFFE, lo=0x00000001.
//   2 MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   3 DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//   4 DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100.
//   5 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//   6 MTHI a=0x1234 -> next cycle hi=0x1234, busy=0, lo unchanged.
//   7 MULT started, rst pulsed at cycle 10 -> busy=0, hi=lo=0 next cycle.
//     - Then start during busy -> ignored; result matches first op.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operand width and the
// operation codes decoded alongside the ALU control.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MDU_OP_MULT  = 3'd0,
        MDU_OP_MULTU = 3'd1,
        MDU_OP_DIV   = 3'd2,
        MDU_OP_DIVU  = 3'd3,
        MDU_OP_MTHI  = 3'd4,
        MDU_OP_MTLO  = 3'd5
    } mduOp_e;

    // Signed variants take magnitudes up front and fix the signs at the end.
    function automatic logic opIsSigned(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The master side issues start/op/a/b; the unit answers with busy and HI/LO.
interface mdu_if import mdu_pkg::*; #(parameter int WIDTH = MDU_WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/mdu_iter_core.sv
// One iteration of the unsigned magnitude datapath.
// Multiply: shift-add on {acc, multiplier}, consuming the multiplier LSB.
// Divide: restoring shift-subtract on {remainder, dividend}, producing one
// quotient bit into the LSB of the shift register.
module mdu_iter_core import mdu_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             isDiv_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] shift_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] shift_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // The subtraction only matters when it fits, so a WIDTH-bit difference is enough.
    always_comb begin
        sum     = {1'b0, acc_i} + (shift_i[0] ? {1'b0, operand_i} : '0);
        shifted = {acc_i, shift_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand_i});
        trial   = shifted[WIDTH-1:0] - operand_i;
        if (isDiv_i) begin
            acc_o   = fits ? trial : shifted[WIDTH-1:0];
            shift_o = {shift_i[WIDTH-2:0], fits};
        end else begin
            acc_o   = sum[WIDTH:1];
            shift_o = {sum[0], shift_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit beside the ALU. Works on operand magnitudes
// for WIDTH cycles, then spends one cycle restoring signs and writing HI/LO.
module mdu import mdu_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] operand_q;
    logic [CW-1:0]    count_q;
    logic             isDiv_q;
    logic             negRes_q;
    logic             negRem_q;
    logic             divZero_q;

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] shift_d;

    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] quotFix;
    logic [WIDTH-1:0] remFix;

    mdu_iter_core #(.WIDTH(WIDTH)) iterCore (
        .isDiv_i   (isDiv_q),
        .acc_i     (acc_q),
        .shift_i   (shift_q),
        .operand_i (operand_q),
        .acc_o     (acc_d),
        .shift_o   (shift_d)
    );

    // Magnitudes of the incoming operands; the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        aNeg = opIsSigned(bus.op) & bus.a[WIDTH-1];
        bNeg = opIsSigned(bus.op) & bus.b[WIDTH-1];
        absA = aNeg ? ('0 - bus.a) : bus.a;
        absB = bNeg ? ('0 - bus.b) : bus.b;
    end

    // Sign restoration; a zero divisor forces the quotient to all ones regardless of signs.
    always_comb begin
        product = negRes_q ? ('0 - {acc_q, shift_q}) : {acc_q, shift_q};
        quotFix = divZero_q ? '1 : (negRes_q ? ('0 - shift_q) : shift_q);
        remFix  = negRem_q ? ('0 - acc_q) : acc_q;
    end

    // Control FSM with HI/LO and iteration registers; start is ignored outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            shift_q   <= '0;
            operand_q <= '0;
            count_q   <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
                                acc_q     <= '0;
                                shift_q   <= absA;
                                operand_q <= absB;
                                count_q   <= '0;
                                isDiv_q   <= bus.op[1];
                                negRes_q  <= aNeg ^ bNeg;
                                negRem_q  <= aNeg;
                                divZero_q <= (bus.b == '0);
                                busy_q    <= 1'b1;
                                state_q   <= bus.op[1] ? S_DIV : S_MUL;
                            end
                            MDU_OP_MTHI: hi_q <= bus.a;
                            MDU_OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q   <= acc_d;
                    shift_q <= shift_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (isDiv_q) begin
                        hi_q <= remFix;
                        lo_q <= quotFix;
                    end else begin
                        {hi_q, lo_q} <= product;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomised self-checking bench for the multiply/divide unit. Expected HI/LO
// come from plain 64-bit arithmetic on the architectural rules.
module tb_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    mdu_if #(.WIDTH(32)) bus ();

    mdu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Architectural result of one operation applied to the model HI/LO.
    function automatic void modelOp(input logic [2:0] opV, input logic [31:0] aV, input logic [31:0] bV);
        logic [63:0] p;
        longint      sp;
        case (opV)
            3'd0: begin
                sp = longint'(int'(aV)) * longint'(int'(bV));
                {modelHi, modelLo} = sp;
            end
            3'd1: begin
                p = {32'd0, aV} * {32'd0, bV};
                {modelHi, modelLo} = p;
            end
            3'd2, 3'd3: begin
                if (bV == 0) begin
                    modelLo = 32'hFFFF_FFFF;
                    modelHi = aV;
                end else if (opV == 3'd3) begin
                    modelLo = aV / bV;
                    modelHi = aV % bV;
                end else if (aV == 32'h8000_0000 && bV == 32'hFFFF_FFFF) begin
                    modelLo = 32'h8000_0000;
                    modelHi = 32'h0;
                end else begin
                    modelLo = int'(aV) / int'(bV);
                    modelHi = int'(aV) % int'(bV);
                end
            end
            3'd4: modelHi = aV;
            3'd5: modelLo = aV;
            default: ;
        endcase
    endfunction

    // Issue one request at a falling edge and follow it to completion.
    task automatic applyStimulus(input logic [2:0] opV, input logic [31:0] aV, input logic [31:0] bV);
        int cycles;
        bus.start = 1'b1;
        bus.op    = opV;
        bus.a     = aV;
        bus.b     = bV;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (opV < 3'd4) begin
            checkOutput("holdHi", bus.hi, modelHi);
            checkOutput("holdLo", bus.lo, modelLo);
            cycles = 0;
            while (bus.busy === 1'b1 && cycles < 100) begin
                cycles++;
                @(negedge clk);
            end
            checkOutput("busyCycles", cycles, 33);
        end else begin
            checkOutput("busyIdle", bus.busy, 0);
        end
        modelOp(opV, aV, bV);
        checkOutput("hi", bus.hi, modelHi);
        checkOutput("lo", bus.lo, modelLo);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cycles;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.a = '0;
        bus.b = '0;
        modelHi = '0;
        modelLo = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstHi", bus.hi, 0);
        checkOutput("rstLo", bus.lo, 0);

        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("t1Hi", bus.hi, 32'hFFFF_FFFE);
        checkOutput("t1Lo", bus.lo, 32'h0000_0001);
        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd7);
        checkOutput("t2Hi", bus.hi, 32'hFFFF_FFFF);
        checkOutput("t2Lo", bus.lo, 32'hFFFF_FFEB);
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
        checkOutput("t3Hi", bus.hi, 32'hFFFF_FFFF);
        checkOutput("t3Lo", bus.lo, 32'hFFFF_FFFD);
        applyStimulus(3'd3, 32'd100, 32'd0);
        checkOutput("t4Hi", bus.hi, 32'd100);
        checkOutput("t4Lo", bus.lo, 32'hFFFF_FFFF);
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("t5Hi", bus.hi, 32'h0);
        checkOutput("t5Lo", bus.lo, 32'h8000_0000);
        applyStimulus(3'd4, 32'h1234, 32'd0);
        checkOutput("t6Hi", bus.hi, 32'h1234);
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd0);
        applyStimulus(3'd7, 32'h5555, 32'h3);

        // Reset in the middle of a multiply.
        bus.start = 1'b1;
        bus.op = 3'd0;
        bus.a = 32'h0001_2345;
        bus.b = 32'hFFFF_0003;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelHi = '0;
        modelLo = '0;
        checkOutput("midRstBusy", bus.busy, 0);
        checkOutput("midRstHi", bus.hi, 0);
        checkOutput("midRstLo", bus.lo, 0);
        @(negedge clk);
        checkOutput("midRstIdle", bus.busy, 0);

        // A second start while busy must be ignored.
        bus.start = 1'b1;
        bus.op = 3'd0;
        bus.a = 32'h0000_7777;
        bus.b = 32'hFFFF_FFF0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 3'd3;
        bus.a = 32'd5;
        bus.b = 32'd1;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            bus.start = (cycles == 5);
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkOutput("ignoreBusyCycles", cycles, 33);
        modelOp(3'd0, 32'h0000_7777, 32'hFFFF_FFF0);
        checkOutput("ignoreHi", bus.hi, modelHi);
        checkOutput("ignoreLo", bus.lo, modelLo);
        @(negedge clk);
        checkOutput("ignoreIdle", bus.busy, 0);

        // Reset wins over a simultaneous start.
        applyStimulus(3'd4, 32'hABCD, 32'd0);
        rst = 1'b1;
        bus.start = 1'b1;
        bus.op = 3'd1;
        bus.a = 32'd9;
        bus.b = 32'd9;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        modelHi = '0;
        modelLo = '0;
        checkOutput("rstWinsBusy", bus.busy, 0);
        checkOutput("rstWinsHi", bus.hi, 0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
